// File: rtl/pipelined_control_unit.sv
// ID-stage decoder with condition evaluation, registered as the ID/EX control
// stage; also sequences multi-cycle MUL by stalling the front end.
module pipelined_control_unit #(
  parameter int CMD_W       = 4,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [1:0]       mode,
  input  logic [3:0]       op_code,
  input  logic             s_in,
  input  logic             is_mul,
  input  logic [3:0]       cond,
  input  logic [3:0]       status,
  input  logic             hazard,
  input  logic             flush,
  output logic [CMD_W-1:0] exe_cmd_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             wb_en_o,
  output logic             b_o,
  output logic             s_o,
  output logic             mul_start_o,
  output logic             valid_o,
  output logic             stall_o
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CMD_W-1:0] exe_cmd_q, exe_cmd_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             wb_en_q, wb_en_d;
  logic             b_q, b_d;
  logic             s_q, s_d;
  logic             mul_start_q, mul_start_d;
  logic             valid_q, valid_d;

  logic [3:0] dec_cmd;
  logic       dec_mem_read, dec_mem_write, dec_wb, dec_b, dec_s;
  logic       dp_known;
  logic       cond_pass;
  logic       mul_op;
  logic       accept;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    dec_cmd       = 4'b0000;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_wb        = 1'b0;
    dec_b         = 1'b0;
    dec_s         = 1'b0;
    dp_known      = 1'b1;
    unique case (mode)
      2'b00: begin
        if (is_mul) begin
          dec_cmd = 4'b1010;
          dec_wb  = 1'b1;
        end else begin
          unique case (op_code)
            4'b1101: begin dec_cmd = 4'b0001; dec_wb = 1'b1; end
            4'b1111: begin dec_cmd = 4'b1001; dec_wb = 1'b1; end
            4'b0100: begin dec_cmd = 4'b0010; dec_wb = 1'b1; end
            4'b0101: begin dec_cmd = 4'b0011; dec_wb = 1'b1; end
            4'b0010: begin dec_cmd = 4'b0100; dec_wb = 1'b1; end
            4'b0110: begin dec_cmd = 4'b0101; dec_wb = 1'b1; end
            4'b0000: begin dec_cmd = 4'b0110; dec_wb = 1'b1; end
            4'b1100: begin dec_cmd = 4'b0111; dec_wb = 1'b1; end
            4'b0001: begin dec_cmd = 4'b1000; dec_wb = 1'b1; end
            4'b1010: dec_cmd = 4'b0100;
            4'b1000: dec_cmd = 4'b0110;
            default: dp_known = 1'b0;
          endcase
        end
        dec_s = s_in & dp_known;
      end
      2'b01: begin
        if (op_code == 4'b0100) begin
          dec_cmd       = 4'b0010;
          dec_mem_read  = s_in;
          dec_wb        = s_in;
          dec_mem_write = ~s_in;
        end
      end
      2'b10:   dec_b = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = status;
    unique case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign mul_op = is_mul & (mode == 2'b00);
  // accept folds in every bubble source: flush, hazard, MUL busy, invalid, cond fail
  assign accept = valid_i & cond_pass & ~hazard & ~flush & (state_q == ST_IDLE);

  always_comb begin
    exe_cmd_d   = '0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    wb_en_d     = 1'b0;
    b_d         = 1'b0;
    s_d         = 1'b0;
    valid_d     = 1'b0;
    mul_start_d = 1'b0;
    if (accept) begin
      exe_cmd_d   = CMD_W'(dec_cmd);
      mem_read_d  = dec_mem_read;
      mem_write_d = dec_mem_write;
      wb_en_d     = dec_wb;
      b_d         = dec_b;
      s_d         = dec_s;
      valid_d     = 1'b1;
      mul_start_d = mul_op;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && mul_op) begin
          state_d = ST_MUL_BUSY;
          cnt_d   = CNT_W'(MUL_LATENCY - 1);
        end
      end
      default: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end
    endcase
  end

  // The last busy cycle releases the stall so the next instruction issues
  // exactly as the FSM returns to IDLE.
  assign stall_o = ~rst & (((state_q == ST_MUL_BUSY) & (cnt_q != CNT_W'(1)) & ~flush) |
                           ((state_q == ST_IDLE) & accept & mul_op));

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      exe_cmd_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wb_en_q     <= 1'b0;
      b_q         <= 1'b0;
      s_q         <= 1'b0;
      mul_start_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exe_cmd_q   <= exe_cmd_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      wb_en_q     <= wb_en_d;
      b_q         <= b_d;
      s_q         <= s_d;
      mul_start_q <= mul_start_d;
      valid_q     <= valid_d;
    end
  end

  assign exe_cmd_o   = exe_cmd_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign wb_en_o     = wb_en_q;
  assign b_o         = b_q;
  assign s_o         = s_q;
  assign mul_start_o = mul_start_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench: directed scenarios then randomized stimulus, all
// compared against an instruction-level reference model.
module tb_pipelined_control_unit;

  localparam int CMD_W       = 4;
  localparam int MUL_LATENCY = 4;
  localparam int CNT_W       = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_i;
  logic [1:0]       mode;
  logic [3:0]       op_code;
  logic             s_in;
  logic             is_mul;
  logic [3:0]       cond;
  logic [3:0]       status;
  logic             hazard;
  logic             flush;
  logic [CMD_W-1:0] exe_cmd_o;
  logic             mem_read_o, mem_write_o, wb_en_o, b_o, s_o;
  logic             mul_start_o, valid_o, stall_o;

  pipelined_control_unit #(
    .CMD_W(CMD_W), .MUL_LATENCY(MUL_LATENCY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mode(mode), .op_code(op_code),
    .s_in(s_in), .is_mul(is_mul), .cond(cond), .status(status),
    .hazard(hazard), .flush(flush), .exe_cmd_o(exe_cmd_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .wb_en_o(wb_en_o),
    .b_o(b_o), .s_o(s_o), .mul_start_o(mul_start_o), .valid_o(valid_o),
    .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cmd;
    logic       mr, mw, wb, b, s, ms, v;
  } ctrl_t;

  int checks = 0;
  int errors = 0;

  // Reference tables for data-processing opcodes.
  logic [3:0] dp_cmd [16];
  logic       dp_wb  [16];
  logic       dp_ok  [16];
  logic [3:0] legal_ops [11] = '{4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6, 4'h0, 4'hC, 4'h1, 4'hA, 4'h8};

  // Cycles the multiplier still occupies EX; 0 means the unit is free.
  int busy_left = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] cd, input logic [3:0] st);
    logic n, z, c, v;
    n = st[3]; z = st[2]; c = st[1]; v = st[0];
    case (cd)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctrl_t ref_decode(input logic [1:0] md, input logic [3:0] op,
                                       input logic s, input logic m);
    ctrl_t r;
    r = '0;
    r.v = 1'b1;
    if (md == 2'b00) begin
      if (m) begin
        r.cmd = 4'hA; r.wb = 1'b1; r.s = s; r.ms = 1'b1;
      end else if (dp_ok[op]) begin
        r.cmd = dp_cmd[op]; r.wb = dp_wb[op]; r.s = s;
      end
    end else if (md == 2'b01 && op == 4'h4) begin
      r.cmd = 4'h2; r.mr = s; r.wb = s; r.mw = !s;
    end else if (md == 2'b10) begin
      r.b = 1'b1;
    end
    return r;
  endfunction

  task automatic check_outputs(input ctrl_t e, input string pfx);
    check({pfx, ".exe_cmd"},   32'(exe_cmd_o),   32'(e.cmd));
    check({pfx, ".mem_read"},  32'(mem_read_o),  32'(e.mr));
    check({pfx, ".mem_write"}, 32'(mem_write_o), 32'(e.mw));
    check({pfx, ".wb_en"},     32'(wb_en_o),     32'(e.wb));
    check({pfx, ".b"},         32'(b_o),         32'(e.b));
    check({pfx, ".s"},         32'(s_o),         32'(e.s));
    check({pfx, ".mul_start"}, 32'(mul_start_o), 32'(e.ms));
    check({pfx, ".valid"},     32'(valid_o),     32'(e.v));
  endtask

  // One ID cycle: drive at negedge, check stall, check registered result after the edge.
  task automatic step(input string tag, input logic v, input logic [1:0] md,
                      input logic [3:0] op, input logic s, input logic m,
                      input logic [3:0] cd, input logic [3:0] st,
                      input logic hz, input logic fl);
    logic  acc, exp_stall, mul;
    ctrl_t exp_q;
    @(negedge clk);
    valid_i = v; mode = md; op_code = op; s_in = s; is_mul = m;
    cond = cd; status = st; hazard = hz; flush = fl;
    mul = m && (md == 2'b00);
    acc = v && ref_cond(cd, st) && !hz && !fl && (busy_left == 0);
    exp_stall = ((busy_left > 1) && !fl) || (acc && mul);
    #1;
    check({tag, ".stall"}, 32'(stall_o), 32'(exp_stall));
    exp_q = acc ? ref_decode(md, op, s, mul) : '0;
    if (fl)                 busy_left = 0;
    else if (busy_left > 0) busy_left--;
    else if (acc && mul)    busy_left = MUL_LATENCY - 1;
    @(posedge clk);
    #1;
    check_outputs(exp_q, tag);
  endtask

  // Asynchronous reset pulse mid-cycle, with a MUL-accepting input pattern applied.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    valid_i = 1'b1; mode = 2'b00; op_code = 4'h0; s_in = 1'b0; is_mul = 1'b1;
    cond = 4'hE; status = 4'h0; hazard = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_outputs('0, tag);
    check({tag, ".stall"}, 32'(stall_o), 32'd0);
    busy_left = 0;
    @(posedge clk);
    #1;
    check_outputs('0, {tag, ".held"});
    @(negedge clk);
    rst = 1'b0;
    valid_i = 1'b0; is_mul = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      dp_cmd[i] = 4'h0; dp_wb[i] = 1'b0; dp_ok[i] = 1'b0;
    end
    dp_cmd[4'hD] = 4'h1; dp_cmd[4'hF] = 4'h9; dp_cmd[4'h4] = 4'h2; dp_cmd[4'h5] = 4'h3;
    dp_cmd[4'h2] = 4'h4; dp_cmd[4'h6] = 4'h5; dp_cmd[4'h0] = 4'h6; dp_cmd[4'hC] = 4'h7;
    dp_cmd[4'h1] = 4'h8; dp_cmd[4'hA] = 4'h4; dp_cmd[4'h8] = 4'h6;
    for (int i = 0; i < 11; i++) begin
      dp_ok[legal_ops[i]] = 1'b1;
      dp_wb[legal_ops[i]] = (legal_ops[i] != 4'hA) && (legal_ops[i] != 4'h8);
    end

    rst = 1'b1;
    valid_i = 1'b1; mode = 2'b00; op_code = 4'h4; s_in = 1'b1; is_mul = 1'b1;
    cond = 4'hE; status = 4'h0; hazard = 1'b0; flush = 1'b0;
    #3;
    check_outputs('0, "reset");
    check("reset.stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    is_mul = 1'b0; valid_i = 1'b0;

    // ADD, LDR, STR
    step("add", 1, 2'b00, 4'h4, 1, 0, 4'hE, 4'h0, 0, 0);
    step("ldr", 1, 2'b01, 4'h4, 1, 0, 4'hE, 4'h0, 0, 0);
    step("str", 1, 2'b01, 4'h4, 0, 0, 4'hE, 4'h0, 0, 0);
    // SUB conditional on EQ: Z clear then Z set
    step("sub_eq_z0", 1, 2'b00, 4'h2, 0, 0, 4'h0, 4'b0000, 0, 0);
    step("sub_eq_z1", 1, 2'b00, 4'h2, 0, 0, 4'h0, 4'b0100, 0, 0);
    step("cond_nv",   1, 2'b00, 4'h4, 1, 0, 4'hF, 4'hF, 0, 0);
    step("branch",    1, 2'b10, 4'h0, 1, 0, 4'hE, 4'h0, 0, 0);
    step("illegal",   1, 2'b11, 4'h4, 1, 0, 4'hE, 4'h0, 0, 0);
    step("nop_op",    1, 2'b00, 4'h3, 1, 0, 4'hE, 4'h0, 0, 0);

    // MUL then ADD held in ID until the multiplier completes
    step("mul", 1, 2'b00, 4'h0, 0, 1, 4'hE, 4'h0, 0, 0);
    for (int i = 0; i < MUL_LATENCY; i++)
      step("mul_follow", 1, 2'b00, 4'h4, 1, 0, 4'hE, 4'h0, 0, 0);

    // MUL aborted by flush in its second busy cycle
    step("mul2",      1, 2'b00, 4'h0, 1, 1, 4'hE, 4'h0, 0, 0);
    step("mul2_b1",   1, 2'b00, 4'h4, 0, 0, 4'hE, 4'h0, 0, 0);
    step("mul2_fl",   1, 2'b00, 4'h4, 0, 0, 4'hE, 4'h0, 0, 1);
    step("after_fl",  1, 2'b00, 4'h4, 0, 0, 4'hE, 4'h0, 0, 0);
    step("fl_and_hz", 1, 2'b00, 4'h4, 0, 1, 4'hE, 4'h0, 1, 1);

    // hazard bubble, then reset in the middle of a MUL
    step("hazard",  1, 2'b00, 4'h4, 1, 0, 4'hE, 4'h0, 1, 0);
    step("mul3",    1, 2'b00, 4'h0, 0, 1, 4'hE, 4'h0, 0, 0);
    step("mul3_b1", 1, 2'b00, 4'h4, 0, 0, 4'hE, 4'h0, 0, 0);
    pulse_reset("rst_mid_mul");
    step("post_rst", 1, 2'b00, 4'hD, 0, 0, 4'hE, 4'h0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      logic       rv, rs, rm, rh, rf;
      logic [1:0] rmd;
      logic [3:0] rop, rcd, rst_flags;
      rv  = ($urandom_range(0, 9) < 8);
      rmd = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
      rop = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 10)] : 4'($urandom);
      if (rmd == 2'b01 && $urandom_range(0, 1) == 1) rop = 4'h4;
      rs  = 1'($urandom);
      rm  = (rmd == 2'b00) && ($urandom_range(0, 99) < 15);
      rcd = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom);
      rst_flags = 4'($urandom);
      rh  = ($urandom_range(0, 99) < 10);
      rf  = ($urandom_range(0, 99) < 7);
      step("rand", rv, rmd, rop, rs, rm, rcd, rst_flags, rh, rf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Parametrised successor to the combinational ID-stage decoder. It decodes mode, opcode and S into execute/memory/write-back controls and evaluates the ARM condition field against the NZCV flags. It registers the result as the ID/EX control pipeline stage, with bubble, flush and stall handling. It also sequences a multi-cycle MUL operation, holding the front end stalled until the multiplier finishes.

Parameters:
CMD_W, 4, width of exe_cmd
MUL_LATENCY, 4, EX cycles a MUL occupies (≥2)
CNT_W, 3, counter width (≥ clog2(MUL_LATENCY))

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
valid_i  in  1  ID stage holds a real instruction
mode  in  2  00 data-proc, 01 memory, 10 branch, 11 illegal
op_code  in  4  data-proc / memory opcode
s_in  in  1  S bit (data-proc: update flags; memory: 1=LDR, 0=STR)
is_mul  in  1  instruction is MUL (mode 00 only)
cond  in  4  ARM condition field
status  in  4  {N,Z,C,V}
hazard  in  1  data hazard, insert bubble this cycle
flush  in  1  branch taken in EX, kill ID instruction and abort MUL
exe_cmd_o  out  CMD_W  registered ALU command
mem_read_o  out  1  registered load enable
mem_write_o  out  1  registered store enable
wb_en_o  out  1  registered write-back enable
b_o  out  1  registered branch
s_o  out  1  registered flag-update enable
mul_start_o  out  1  registered one-cycle pulse that starts the multiplier
valid_o  out  1  registered: EX stage holds a real instruction
stall_o  out  1  combinational: freeze PC and IF/ID

Behaviour:
- Reset (async): all registered outputs 0; FSM = IDLE; counter = 0. stall_o = 0 while in reset.
- Decode, mode 00 (exe_cmd, wb):
  - MOV 1101→0001, wb 1
  - MVN 1111→1001, wb 1
  - ADD 0100→0010, wb 1
  - ADC 0101→0011, wb 1
  - SUB 0010→0100, wb 1
  - SBC 0110→0101, wb 1
  - AND 0000→0110, wb 1
  - ORR 1100→0111, wb 1
  - EOR 0001→1000, wb 1
  - CMP 1010→0100, wb 0
  - TST 1000→0110, wb 0
  - is_mul=1 overrides the opcode: exe_cmd 1010, wb 1.
  - Any other opcode: all controls 0, valid_o 1 (treated as NOP).
  - s = s_in.
- Decode, mode 01: opcode 0100 only. exe_cmd 0010, s = 0. s_in=1: mem_read 1, wb 1. s_in=0: mem_write 1, wb 0. Other opcodes give all controls 0.
- Decode, mode 10: b 1, all others 0.
- Decode, mode 11: all controls 0.
- Condition check: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL evaluated per standard ARM on status; 1111 fails.
- "Accept" = valid_i & cond pass & !hazard & !flush & state==IDLE.
- Register update, priority high→low:
  - flush: bubble (all controls 0, valid_o 0).
  - hazard: bubble.
  - state==MUL_BUSY: bubble.
  - !valid_i or cond fail: bubble.
  - Otherwise: load decoded controls, valid_o 1.
- FSM:
  - IDLE: on accept with is_mul, load MUL controls, mul_start_o=1, counter←MUL_LATENCY-1, go to MUL_BUSY.
  - MUL_BUSY: mul_start_o=0; counter decrements each cycle. Flush → IDLE, counter 0 (abort). Counter==1 → IDLE next edge.
  - mul_start_o is 1 only on the acceptance-edge register load.
- stall_o = (state==MUL_BUSY & counter!=1 & !flush) | (state==IDLE & accept & is_mul).
  - Result: the instruction after MUL waits exactly MUL_LATENCY-1 cycles in ID.
- Latency: 1 clock from ID inputs to registered outputs; no combinational path from inputs to registered outputs.
- Simultaneous flush+hazard: flush wins (bubble, no stall).
- Reset mid-MUL: immediate return to IDLE, stall_o 0.

Test Plan:
- ADD, mode 00, op 0100, s_in 1, cond AL, valid_i 1 → next edge exe_cmd_o 0010, wb_en_o 1, s_o 1, valid_o 1.
- LDR then STR, mode 01, op 0100, s_in 1 then 0 → mem_read_o 1/wb_en_o 1, then mem_write_o 1/wb_en_o 0; exe_cmd_o 0010; s_o 0.
- SUB with cond EQ, status Z=0 → bubble (all 0, valid_o 0). Same with Z=1 → exe_cmd_o 0100.
- MUL, MUL_LATENCY 4 → mul_start_o pulses once; stall_o high 3 cycles; valid_o 0 for 3 cycles after MUL; next instruction issues on cycle 4.
- Flush asserted during the 2nd MUL_BUSY cycle → stall_o drops the same cycle, FSM IDLE next edge, outputs bubble.
- hazard=1 with ADD, then rst pulsed mid-MUL → bubble, then all outputs 0 and stall_o 0 asynchronously.
